// File: rtl/lsu_subword_ctrl.sv
// Load/store unit between execute and word-addressed data memory.
// Sub-word loads extract in place; SB/SH are a two-cycle read-modify-write.
module lsu_subword_ctrl #(
  parameter int addrWidth = 32,
  parameter int ramHeight = 2048,
  parameter int ramWidth  = 32
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [2:0]           funct3_i,
  input  logic [addrWidth-1:0] addr_i,
  input  logic [ramWidth-1:0]  wdata_i,
  output logic [ramWidth-1:0]  rdata_o,
  output logic                 busy_o,
  output logic                 fault_o,
  output logic [addrWidth-1:0] fault_addr_o,
  output logic                 mem_rd_o,
  output logic                 mem_wrt_o,
  output logic [addrWidth-1:0] mem_addr_o,
  output logic [ramWidth-1:0]  mem_wdata_o,
  input  logic [ramWidth-1:0]  mem_rdata_i
);

  typedef enum logic {IDLE, RMW_WR} state_e;

  localparam logic [addrWidth-1:0] IdxLim = addrWidth'(ramHeight);

  state_e               state_q;
  logic [31:0]          word_q;
  logic [addrWidth-1:0] idx_q;
  logic [1:0]           off_q;
  logic                 half_q;
  logic [15:0]          wd_q;
  logic [addrWidth-1:0] fault_addr_q;

  logic [addrWidth-1:0] idx;
  logic is_b, is_h, is_w, is_bu, is_hu;
  logic bad_f3, misal, oor;
  logic act, flt, ld, sw, sub_st, rmw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] rdata;
  logic [4:0]  sh;
  logic [31:0] mask, ins, merged;

  assign idx = addr_i >> 2;

  always_comb begin
    is_b   = funct3_i == 3'b000;
    is_h   = funct3_i == 3'b001;
    is_w   = funct3_i == 3'b010;
    is_bu  = funct3_i == 3'b100;
    is_hu  = funct3_i == 3'b101;
    bad_f3 = !(is_b | is_h | is_w | is_bu | is_hu)
           | (we_i & (is_bu | is_hu));
    misal  = ((is_h | is_hu) & addr_i[0])
           | (is_w & |addr_i[1:0]);
    oor    = idx >= IdxLim;
    // rst_ gates the strobes so nothing leaks while reset is held
    act    = rst_ & req_i & (state_q == IDLE);
    flt    = act & (bad_f3 | misal | oor);
    ld     = act & !flt & !we_i;
    sw     = act & !flt & we_i & is_w;
    sub_st = act & !flt & we_i & (is_b | is_h);
    rmw    = rst_ & (state_q == RMW_WR);
  end

  always_comb begin
    byte_sel = mem_rdata_i[{addr_i[1:0], 3'b000} +: 8];
    half_sel = addr_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    rdata    = '0;
    if (ld) begin
      unique case (1'b1)
        is_b:    rdata = {{24{byte_sel[7]}}, byte_sel};
        is_bu:   rdata = {24'b0, byte_sel};
        is_h:    rdata = {{16{half_sel[15]}}, half_sel};
        is_hu:   rdata = {16'b0, half_sel};
        is_w:    rdata = mem_rdata_i;
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    sh     = {off_q, 3'b000};
    mask   = (half_q ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    ins    = {16'b0, wd_q} << sh;
    merged = (word_q & ~mask) | (ins & mask);
  end

  assign rdata_o      = rdata;
  assign busy_o       = sub_st;
  assign fault_o      = flt;
  assign fault_addr_o = fault_addr_q;
  assign mem_rd_o     = ld | sub_st;
  assign mem_wrt_o    = sw | rmw;
  assign mem_addr_o   = rmw ? idx_q : idx;
  assign mem_wdata_o  = rmw ? merged : wdata_i;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      half_q       <= 1'b0;
      wd_q         <= '0;
      fault_addr_q <= '0;
    end else begin
      if (flt) fault_addr_q <= addr_i;
      unique case (state_q)
        IDLE: begin
          if (sub_st) begin
            state_q <= RMW_WR;
            word_q  <= mem_rdata_i;
            idx_q   <= idx;
            off_q   <= addr_i[1:0];
            half_q  <= is_h;
            wd_q    <= wdata_i[15:0];
          end
        end
        RMW_WR:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Directed bench for lsu_subword_ctrl with a behavioural word memory.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_lsu_subword_ctrl;

  logic        clk = 1'b0;
  logic        rst_;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        fault;
  logic [31:0] fault_addr;
  logic        mem_rd;
  logic        mem_wrt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:2047] = '{default: 32'h0};
  int wr_cnt = 0;
  int cmp = 0;
  int errs = 0;

  always #5 clk = ~clk;

  lsu_subword_ctrl #(
    .addrWidth(32),
    .ramHeight(2048),
    .ramWidth(32)
  ) dut (
    .clk(clk),
    .rst_(rst_),
    .req_i(req),
    .we_i(we),
    .funct3_i(funct3),
    .addr_i(addr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .busy_o(busy),
    .fault_o(fault),
    .fault_addr_o(fault_addr),
    .mem_rd_o(mem_rd),
    .mem_wrt_o(mem_wrt),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32'd2048) ? mem[mem_addr[10:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_wrt && mem_addr < 32'd2048) begin
      mem[mem_addr[10:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic op(input logic r, input logic w, input logic [2:0] f,
                    input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = r; we = w; funct3 = f; addr = a; wdata = d;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
    #3;
    cmp++; if (mem_rd !== 1'b0) begin errs++; $display("FAIL rst_mem_rd got %b want 0", mem_rd); end
    cmp++; if (mem_wrt !== 1'b0) begin errs++; $display("FAIL rst_mem_wrt got %b want 0", mem_wrt); end
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
    cmp++; if (rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata got %h want 0", rdata); end
    cmp++; if (fault_addr !== 32'h0) begin errs++; $display("FAIL rst_fault_addr got %h want 0", fault_addr); end
    @(negedge clk);
    rst_ = 1'b1;
    req = 1'b0;
  endtask

  task automatic test_sw();
    op(1, 1, 3'b010, 32'h10, 32'h8899AABB);
    cmp++; if (mem_wrt !== 1'b1) begin errs++; $display("FAIL sw_wrt got %b want 1", mem_wrt); end
    cmp++; if (mem_rd !== 1'b0) begin errs++; $display("FAIL sw_rd got %b want 0", mem_rd); end
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL sw_busy got %b want 0", busy); end
    cmp++; if (mem_addr !== 32'h4) begin errs++; $display("FAIL sw_addr got %h want 4", mem_addr); end
    cmp++; if (mem_wdata !== 32'h8899AABB) begin errs++; $display("FAIL sw_wdata got %h want 8899aabb", mem_wdata); end
  endtask

  task automatic test_loads();
    op(1, 0, 3'b010, 32'h10, 32'h0);
    cmp++; if (mem_rd !== 1'b1) begin errs++; $display("FAIL lw_rd got %b want 1", mem_rd); end
    cmp++; if (mem_addr !== 32'h4) begin errs++; $display("FAIL lw_addr got %h want 4", mem_addr); end
    cmp++; if (rdata !== 32'h8899AABB) begin errs++; $display("FAIL lw_rdata got %h want 8899aabb", rdata); end
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL lw_busy got %b want 0", busy); end
    op(1, 0, 3'b000, 32'h13, 32'h0);
    cmp++; if (rdata !== 32'hFFFFFF88) begin errs++; $display("FAIL lb13 got %h want ffffff88", rdata); end
    op(1, 0, 3'b100, 32'h13, 32'h0);
    cmp++; if (rdata !== 32'h00000088) begin errs++; $display("FAIL lbu13 got %h want 00000088", rdata); end
    op(1, 0, 3'b001, 32'h12, 32'h0);
    cmp++; if (rdata !== 32'hFFFF8899) begin errs++; $display("FAIL lh12 got %h want ffff8899", rdata); end
    op(1, 0, 3'b101, 32'h10, 32'h0);
    cmp++; if (rdata !== 32'h0000AABB) begin errs++; $display("FAIL lhu10 got %h want 0000aabb", rdata); end
    op(1, 0, 3'b000, 32'h10, 32'h0);
    cmp++; if (rdata !== 32'hFFFFFFBB) begin errs++; $display("FAIL lb10 got %h want ffffffbb", rdata); end
    op(1, 0, 3'b100, 32'h11, 32'h0);
    cmp++; if (rdata !== 32'h000000AA) begin errs++; $display("FAIL lbu11 got %h want 000000aa", rdata); end
    op(1, 0, 3'b001, 32'h10, 32'h0);
    cmp++; if (rdata !== 32'hFFFFAABB) begin errs++; $display("FAIL lh10 got %h want ffffaabb", rdata); end
    op(0, 0, 3'b010, 32'h10, 32'h0);
    cmp++; if (mem_rd !== 1'b0 || rdata !== 32'h0) begin errs++; $display("FAIL idle rd %b rdata %h want 0 0", mem_rd, rdata); end
  endtask

  task automatic test_sb();
    op(1, 1, 3'b000, 32'h11, 32'h123456CD);
    cmp++; if (busy !== 1'b1) begin errs++; $display("FAIL sb_c1_busy got %b want 1", busy); end
    cmp++; if (mem_rd !== 1'b1) begin errs++; $display("FAIL sb_c1_rd got %b want 1", mem_rd); end
    cmp++; if (mem_wrt !== 1'b0) begin errs++; $display("FAIL sb_c1_wrt got %b want 0", mem_wrt); end
    step();
    cmp++; if (mem_wrt !== 1'b1) begin errs++; $display("FAIL sb_c2_wrt got %b want 1", mem_wrt); end
    cmp++; if (mem_rd !== 1'b0) begin errs++; $display("FAIL sb_c2_rd got %b want 0", mem_rd); end
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL sb_c2_busy got %b want 0", busy); end
    cmp++; if (mem_addr !== 32'h4) begin errs++; $display("FAIL sb_c2_addr got %h want 4", mem_addr); end
    cmp++; if (mem_wdata !== 32'h8899CDBB) begin errs++; $display("FAIL sb_c2_wdata got %h want 8899cdbb", mem_wdata); end
    op(1, 0, 3'b010, 32'h10, 32'h0);
    cmp++; if (rdata !== 32'h8899CDBB) begin errs++; $display("FAIL sb_readback got %h want 8899cdbb", rdata); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    op(1, 1, 3'b010, 32'h10, 32'h0);
    op(1, 1, 3'b001, 32'h12, 32'h0000BEEF);
    pulses += int'(busy);
    step();
    pulses += int'(busy);
    cmp++; if (mem_wdata !== 32'hBEEF0000) begin errs++; $display("FAIL b2b_sh_wdata got %h want beef0000", mem_wdata); end
    op(1, 1, 3'b000, 32'h10, 32'h00000055);
    pulses += int'(busy);
    cmp++; if (mem_rd !== 1'b1 || mem_wrt !== 1'b0) begin errs++; $display("FAIL b2b_sb_c1 rd %b wrt %b want 1 0", mem_rd, mem_wrt); end
    step();
    pulses += int'(busy);
    cmp++; if (mem_wdata !== 32'hBEEF0055) begin errs++; $display("FAIL b2b_sb_wdata got %h want beef0055", mem_wdata); end
    cmp++; if (pulses != 2) begin errs++; $display("FAIL b2b_busy_pulses got %0d want 2", pulses); end
    op(1, 0, 3'b010, 32'h10, 32'h0);
    cmp++; if (rdata !== 32'hBEEF0055) begin errs++; $display("FAIL b2b_readback got %h want beef0055", rdata); end
  endtask

  task automatic test_faults();
    op(1, 0, 3'b010, 32'h06, 32'h0);
    cmp++; if (fault !== 1'b1) begin errs++; $display("FAIL lw06_fault got %b want 1", fault); end
    cmp++; if (mem_rd !== 1'b0 || mem_wrt !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0)
      begin errs++; $display("FAIL lw06_quiet rd %b wrt %b busy %b rdata %h want 0 0 0 0", mem_rd, mem_wrt, busy, rdata); end
    op(1, 1, 3'b001, 32'h03, 32'h1234);
    cmp++; if (fault_addr !== 32'h06) begin errs++; $display("FAIL fa06 got %h want 6", fault_addr); end
    cmp++; if (fault !== 1'b1 || mem_rd !== 1'b0 || busy !== 1'b0)
      begin errs++; $display("FAIL sh03 fault %b rd %b busy %b want 1 0 0", fault, mem_rd, busy); end
    op(1, 0, 3'b000, 32'h2000, 32'h0);
    cmp++; if (fault_addr !== 32'h03) begin errs++; $display("FAIL fa03 got %h want 3", fault_addr); end
    cmp++; if (fault !== 1'b1 || mem_rd !== 1'b0) begin errs++; $display("FAIL lb2000 fault %b rd %b want 1 0", fault, mem_rd); end
    op(1, 0, 3'b011, 32'h10, 32'h0);
    cmp++; if (fault_addr !== 32'h2000) begin errs++; $display("FAIL fa2000 got %h want 2000", fault_addr); end
    cmp++; if (fault !== 1'b1 || mem_rd !== 1'b0) begin errs++; $display("FAIL f3_011 fault %b rd %b want 1 0", fault, mem_rd); end
    op(1, 1, 3'b100, 32'h14, 32'h0);
    cmp++; if (fault !== 1'b1 || mem_wrt !== 1'b0 || busy !== 1'b0)
      begin errs++; $display("FAIL sbu fault %b wrt %b busy %b want 1 0 0", fault, mem_wrt, busy); end
    op(1, 0, 3'b000, 32'h1FFF, 32'h0);
    cmp++; if (fault !== 1'b0 || mem_rd !== 1'b1) begin errs++; $display("FAIL lb1fff fault %b rd %b want 0 1", fault, mem_rd); end
    cmp++; if (mem_addr !== 32'h7FF) begin errs++; $display("FAIL lb1fff_addr got %h want 7ff", mem_addr); end
    op(0, 0, 3'b010, 32'h0, 32'h0);
    cmp++; if (fault_addr !== 32'h14) begin errs++; $display("FAIL fa14 got %h want 14", fault_addr); end
  endtask

  task automatic test_reset_rmw();
    int wc;
    op(1, 1, 3'b010, 32'h20, 32'h11223344);
    op(1, 1, 3'b000, 32'h20, 32'h000000AA);
    cmp++; if (busy !== 1'b1) begin errs++; $display("FAIL rr_c1_busy got %b want 1", busy); end
    step();
    cmp++; if (mem_wrt !== 1'b1) begin errs++; $display("FAIL rr_c2_wrt got %b want 1", mem_wrt); end
    wc = wr_cnt;
    rst_ = 1'b0;
    #1;
    cmp++; if (mem_wrt !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b0)
      begin errs++; $display("FAIL rr_quiet wrt %b rd %b busy %b want 0 0 0", mem_wrt, mem_rd, busy); end
    cmp++; if (fault_addr !== 32'h0) begin errs++; $display("FAIL rr_fault_addr got %h want 0", fault_addr); end
    step();
    cmp++; if (wr_cnt != wc) begin errs++; $display("FAIL rr_no_write got %0d writes want 0", wr_cnt - wc); end
    cmp++; if (mem[8] !== 32'h11223344) begin errs++; $display("FAIL rr_mem8 got %h want 11223344", mem[8]); end
    req = 1'b0;
    rst_ = 1'b1;
    op(1, 0, 3'b010, 32'h20, 32'h0);
    cmp++; if (mem_rd !== 1'b1 || mem_wrt !== 1'b0 || busy !== 1'b0)
      begin errs++; $display("FAIL rr_idle rd %b wrt %b busy %b want 1 0 0", mem_rd, mem_wrt, busy); end
    cmp++; if (rdata !== 32'h11223344) begin errs++; $display("FAIL rr_lw got %h want 11223344", rdata); end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_loads();
    test_sb();
    test_back_to_back();
    test_faults();
    test_reset_rmw();
    op(0, 0, 3'b010, 32'h0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule

// File: doc/lsu_subword_ctrl.md
Name: lsu_subword_ctrl

Overview:
Load/store unit between the single-cycle core's execute stage and the word-addressed data memory.
- Converts byte addresses to word indices and checks alignment and range.
- Extracts and sign/zero-extends sub-word load data.
- Performs SB/SH as a two-cycle read-modify-write, stalling the core for one cycle.
- The core sees loads and SW as single-cycle.

Parameters:
addrWidth, 32, width of core byte address and of memory address port
ramHeight, 2048, memory depth in 32-bit words; word index >= ramHeight is out of range
ramWidth, 32, data width (fixed at 32; other values unsupported)

Ports:
clk  input  1  clock, rising edge
rst_  input  1  asynchronous active-low reset
req  input  1  core requests a memory op this cycle; held stable by core while busy=1
we  input  1  1=store, 0=load
funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  addrWidth  byte address from ALU
wdata  input  32  store data (rs2)
rdata  output  32  extended load result, combinational
busy  output  1  stall core PC/regfile write this cycle
fault  output  1  combinational: misaligned, out-of-range or illegal funct3 on current req
fault_addr  output  addrWidth  registered byte address of most recent faulting req
mem_rd  output  1  to memory read enable
mem_wrt  output  1  to memory write enable
mem_addr  output  addrWidth  word index = addr >> 2 (captured index during RMW_WR)
mem_wdata  output  32  to memory write data
mem_rdata  input  32  from memory, combinational read

Behaviour:
- Reset (async, rst_=0): state=IDLE, capture word=0, captured index/offset/size=0, fault_addr=0. Outputs in reset: mem_rd=0, mem_wrt=0, busy=0, rdata=0.
- FSM states: IDLE, RMW_WR.
- fault conditions, evaluated in IDLE with req=1:
  - funct3 in {011, 110, 111};
  - stores with funct3 100/101 (BU/HU store encodings are illegal);
  - H op with addr[0]=1;
  - W op with addr[1:0]!=0;
  - (addr>>2) >= ramHeight.
- On a fault: mem_rd=mem_wrt=0, busy=0, rdata=0. fault_addr <= addr at the clock edge. No state change.
- IDLE, req=0: all memory strobes 0, rdata=0, busy=0.
- IDLE, load, no fault:
  - mem_rd=1, mem_addr=addr>>2, busy=0.
  - Lane select by addr[1:0] (byte) or addr[1] (half), little-endian.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Zero-cycle latency.
- IDLE, SW, no fault: mem_wrt=1, mem_wdata=wdata, busy=0. Memory updates at this edge.
- IDLE, SB/SH, no fault:
  - mem_rd=1, busy=1.
  - At the edge: capture mem_rdata, word index, addr[1:0], size and wdata; state -> RMW_WR.
- RMW_WR:
  - mem_rd=0, mem_wrt=1, busy=0.
  - mem_addr = captured index.
  - mem_wdata = captured word with the selected byte/half lane replaced by wdata[7:0]/wdata[15:0]; all other bits unchanged.
  - Next state IDLE unconditionally.
  - req/addr inputs are ignored in this state.
- Total store latency: 2 cycles, 1 stall.
- mem_rd and mem_wrt are never both 1 in the same cycle.
- Reset asserted in RMW_WR: return to IDLE immediately, no write issued. Memory-side reset clears contents independently.
- Back-to-back SB: the second SB starts RMW in the cycle after RMW_WR and reads the updated word.

Test Plan:
- Reset, then LW addr 0x10 with mem word 4 = 0x8899AABB -> mem_rd=1, mem_addr=4, rdata=0x8899AABB, busy=0.
- LB addr 0x13 on word 0x8899AABB -> rdata=0xFFFFFF88. LBU same address -> 0x00000088. LH addr 0x12 -> 0xFFFF8899. LHU addr 0x10 -> 0x0000AABB.
- SB addr 0x11, wdata=0x123456CD, word 4=0x8899AABB:
  - cycle1: busy=1, mem_rd=1.
  - cycle2: mem_wrt=1, mem_wdata=0x8899CDBB, busy=0.
  - Subsequent LW addr 0x10 -> 0x8899CDBB.
- SH addr 0x12 then SB addr 0x10 back-to-back, word 0 initial: SH wdata=0xBEEF, SB wdata=0x55 -> final word 0xBEEF0055. Busy pulses once per store.
- Faults, each with no strobes and fault=1:
  - LW 0x06 -> fault_addr=0x06 next cycle.
  - SH 0x03 -> fault_addr=0x03.
  - LB 0x2000 (index 2048) -> fault_addr=0x2000.
  - funct3=011 -> fault=1.
- Assert rst_=0 during RMW_WR of SB addr 0x20 -> mem_wrt drops immediately, state IDLE, busy=0, fault_addr=0. No write observed at memory.
